fabosc_clken_gen: RTL
=====================

# fabosc_clken_gen

Parametrised multi-channel clock-enable generator driven from the fabric copy of the on-chip RC oscillator (the global-buffered 50 MHz O2F net). It produces NUM_CH independent, runtime-programmable divide-by-N enable strobes and matching square-wave ticks. A start-up qualification counter gates every output until the oscillator is declared stable. Downstream fabric logic (UART baud ticks, GPIO debounce, timers) uses these enables instead of deriving extra clock nets.

## Interface
- NUM_CH, 4: number of independent channels (1..16).
- DIV_W, 16: divisor width in bits.
- DIV_RESET, 50: active divisor of every channel after reset (must fit DIV_W).
- STARTUP_CYCLES, 1024: cycles after reset release before OSC_READY asserts (>=1).
- CLK  input  1  fabric oscillator clock; the only clock.
- RESETN  input  1  asynchronous, active-low reset; deassertion synchronous to CLK is the integrator's responsibility.
- CH_EN  input  NUM_CH  per-channel run enable, level.
- DIV_WE  input  NUM_CH  per-channel divisor write strobe, one cycle.
- DIV_IN  input  NUM_CH*DIV_W  per-channel divisor; channel k occupies bits [k*DIV_W +: DIV_W].
- SYNC  input  1  phase-align strobe (present only with FABOSC_CLKEN_SYNC_EN).
- OSC_READY  output  1  start-up qualification complete.
- CLKEN_O  output  NUM_CH  one-cycle enable pulse per divided period.
- CLK_SQ  output  NUM_CH  50 % duty tick, toggles on each CLKEN_O pulse; data signal, never used as a clock.

## Operation
- Reset values: OSC_READY=0, CLKEN_O=0, CLK_SQ=0, startup counter=0, each channel shadow and active divisor = DIV_RESET, counter = DIV_RESET-1.
- Startup: counter increments from reset release; OSC_READY registers high when count reaches STARTUP_CYCLES, then stays high until reset. Counter saturates.
- Before OSC_READY, every channel behaves as if CH_EN=0.
- Divisor N: effective N = max(DIV_IN,1); value 0 treated as 1.
- DIV_WE[k] loads the shadow of channel k. Active divisor takes the shadow only at a reload; no partial or truncated period is ever emitted.
- Channel run (enabled and ready): down-counter; at count 0, CLKEN_O pulses, CLK_SQ toggles, and the counter reloads shadow-1 with active divisor := shadow. Otherwise it decrements.
- Channel idle (CH_EN=0 or not ready): counter forced to shadow-1, active divisor := shadow, CLKEN_O=0, CLK_SQ held at current value.
- Channels are fully independent; no shared arithmetic beyond the SYNC broadcast.

## Timing
- All outputs are registered; no combinational input-to-output path.
- CH_EN first sampled high at edge t: first CLKEN_O pulse is high in the cycle after edge t+N-1, then every N cycles. N=1 gives CLKEN_O continuously high.
- CLK_SQ period = 2N cycles, changing on the same edge that raises CLKEN_O.
- DIV_WE coincident with terminal count: the reload uses the pre-write shadow, and the new value takes effect at the following terminal.
- Two DIV_WE before a terminal: last write wins.
- CH_EN falling on the terminal cycle: no pulse, because idle has priority.
- Reset mid-operation: all outputs return to reset values asynchronously, and OSC_READY requalifies for the full STARTUP_CYCLES.

## Configuration
- FABOSC_CLKEN_SYNC_EN defined: SYNC port exists. SYNC high while OSC_READY forces every enabled channel to reload (shadow-1, active := shadow), clears CLK_SQ to 0, and suppresses CLKEN_O that cycle. SYNC beats terminal count.
- Undefined: SYNC port and logic are absent; channel phases depend only on their individual CH_EN history.

## Structure
- Shared package fabosc_pkg: DIV_RESET default, STARTUP_CYCLES default, the divisor-clamp function (0 -> 1), and a channel-state typedef (counter, shadow, active divisor, square bit).
- Sub-module fabosc_clken_ch: one channel (counter, shadow, reload, square toggle), instantiated NUM_CH times in a generate loop. The top level holds the startup counter, ready flag and SYNC fan-out.

## Test plan
- Reset release, CH_EN=all 1, STARTUP_CYCLES=1024 -> OSC_READY rises exactly 1024 cycles after release; no CLKEN_O before it; first channel-0 pulse 50 cycles after ready.
- Channel 1 DIV_IN=3 written mid-period of N=50 -> the current 50-cycle period completes intact, then pulses recur every 3 cycles and CLK_SQ period = 6.
- DIV_IN=0 and DIV_IN=1 -> CLKEN_O continuously high and CLK_SQ toggling every cycle, in both cases.
- DIV_WE on the terminal cycle (old N=4, new N=7) -> next period is 4, subsequent periods are 7.
- CH_EN dropped on terminal cycle, then raised 10 cycles later -> no pulse on the drop cycle; CLK_SQ held; first pulse N cycles after re-enable.
- With FABOSC_CLKEN_SYNC_EN, channels at N=5 and N=10 out of phase, SYNC pulse -> both CLK_SQ=0, no pulse that cycle, then coincident pulses every 10 cycles.

Source files
------------

// File: rtl/fabosc_pkg.sv
// Shared types, defaults and the divisor clamp for the fabric-oscillator clock-enable generator.
// Divisors up to DIV_W_MAX bits are supported; narrower DIV_W values are zero-extended into the state.
package fabosc_pkg;

   localparam int DIV_W_MAX          = 32;
   localparam int DIV_RESET_DEF      = 50;
   localparam int STARTUP_CYCLES_DEF = 1024;

   typedef logic [DIV_W_MAX-1:0] div_t;

   typedef struct packed {
      div_t cnt;
      div_t shadow;
      div_t active;
      logic sq;
   } ch_state_t;

   function automatic div_t clamp_div(input div_t d);
      return (d == '0) ? div_t'(1) : d;
   endfunction

endpackage

// File: rtl/fabosc_clken_ch.sv
// One divide-by-N enable channel: shadow/active divisor, down-counter, square-wave toggle.
// The phase-align input exists only when FABOSC_CLKEN_SYNC_EN is defined.
module fabosc_clken_ch
   import fabosc_pkg::*;
#(
   parameter int DIV_W     = 16,
   parameter int DIV_RESET = DIV_RESET_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
`ifdef FABOSC_CLKEN_SYNC_EN
   input  logic             sync_ld,
`endif
   input  logic             div_we,
   input  logic [DIV_W-1:0] div_in,
   output logic             clken,
   output logic             sq
);

   localparam div_t RST_DIV = clamp_div(div_t'(DIV_RESET));

   ch_state_t st;
   ch_state_t nxt;
   logic      clken_nxt;
   logic      sync_hit;

`ifdef FABOSC_CLKEN_SYNC_EN
   assign sync_hit = sync_ld;
`else
   assign sync_hit = 1'b0;
`endif

   // Reloads always take the registered shadow, so a write landing on a terminal
   // edge only affects the period after next.
   always_comb begin
      nxt       = st;
      clken_nxt = 1'b0;
      if (div_we)
         nxt.shadow = clamp_div(div_t'(div_in));
      if (sync_hit || !run || st.cnt == '0) begin
         nxt.active = st.shadow;
         nxt.cnt    = nxt.active - div_t'(1);
      end else begin
         nxt.cnt    = st.cnt - div_t'(1);
      end
      if (sync_hit) begin
         nxt.sq = 1'b0;
      end else if (run && st.cnt == '0) begin
         clken_nxt = 1'b1;
         nxt.sq    = ~st.sq;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st    <= '{cnt: RST_DIV - div_t'(1), shadow: RST_DIV, active: RST_DIV, sq: 1'b0};
         clken <= 1'b0;
      end else begin
         st    <= nxt;
         clken <= clken_nxt;
      end
   end

   assign sq = st.sq;

endmodule

// File: rtl/fabosc_clken_gen.sv
// Multi-channel clock-enable generator on the fabric RC-oscillator clock, gated by start-up qualification.
// Define FABOSC_CLKEN_SYNC_EN to add the SYNC phase-align port.
module fabosc_clken_gen
   import fabosc_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int DIV_W          = 16,
   parameter int DIV_RESET      = DIV_RESET_DEF,
   parameter int STARTUP_CYCLES = STARTUP_CYCLES_DEF
) (
   input  logic                    CLK,
   input  logic                    RESETN,
   input  logic [NUM_CH-1:0]       CH_EN,
   input  logic [NUM_CH-1:0]       DIV_WE,
   input  logic [NUM_CH*DIV_W-1:0] DIV_IN,
`ifdef FABOSC_CLKEN_SYNC_EN
   input  logic                    SYNC,
`endif
   output logic                    OSC_READY,
   output logic [NUM_CH-1:0]       CLKEN_O,
   output logic [NUM_CH-1:0]       CLK_SQ
);

   localparam int SU_W = $clog2(STARTUP_CYCLES + 1);

   logic [SU_W-1:0] su_cnt;

   // Saturating qualification counter; ready is sticky until the next reset.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         su_cnt    <= '0;
         OSC_READY <= 1'b0;
      end else begin
         if (su_cnt != SU_W'(STARTUP_CYCLES))
            su_cnt <= su_cnt + SU_W'(1);
         if (su_cnt == SU_W'(STARTUP_CYCLES - 1))
            OSC_READY <= 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic run;
      assign run = CH_EN[k] & OSC_READY;

      fabosc_clken_ch #(
         .DIV_W     (DIV_W),
         .DIV_RESET (DIV_RESET)
      ) u_ch (
         .clk     (CLK),
         .rst_n   (RESETN),
         .run     (run),
`ifdef FABOSC_CLKEN_SYNC_EN
         .sync_ld (SYNC & run),
`endif
         .div_we  (DIV_WE[k]),
         .div_in  (DIV_IN[k*DIV_W +: DIV_W]),
         .clken   (CLKEN_O[k]),
         .sq      (CLK_SQ[k])
      );
   end

endmodule
